// File: rtl/cnt_seq_ctrl.sv
// Command sequencer for counter_ud: loads a start value, sets direction, then counts
// rollovers until a programmed target is reached or the command is aborted.
module cnt_seq_ctrl #(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_load,
    input  logic              cmd_down,
    input  logic [WRAP_W-1:0] cmd_wraps,
    input  logic              abort,
    output logic [WIDTH-1:0]  cnt_load,
    output logic              cnt_load_en,
    output logic              cnt_down,
    input  logic              cnt_rollover,
    input  logic [WIDTH-1:0]  cnt_count,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic [WIDTH-1:0]  last_count
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRun,
        StDone
    } state_e;

    localparam logic [WRAP_W-1:0] WrapMax = '1;
    localparam logic [WRAP_W:0]   WrapOne = {{WRAP_W{1'b0}}, 1'b1};

    state_e            state;
    logic [WRAP_W-1:0] target_q;
    logic [WRAP_W:0]   wrap_next;

    // One extra bit so the target comparison holds even when target is the max value.
    assign wrap_next = {1'b0, wrap_cnt} + WrapOne;
    assign cmd_ready = (state == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            target_q    <= '0;
            cnt_load    <= '0;
            cnt_load_en <= 1'b0;
            cnt_down    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            wrap_cnt    <= '0;
            last_count  <= '0;
        end else begin
            done        <= 1'b0;
            aborted     <= 1'b0;
            cnt_load_en <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cnt_load    <= cmd_load;
                        cnt_down    <= cmd_down;
                        target_q    <= cmd_wraps;
                        wrap_cnt    <= '0;
                        cnt_load_en <= 1'b1;
                        busy        <= 1'b1;
                        state       <= StLoad;
                    end
                end
                StLoad: begin
                    // Rollovers seen here belong to the previous free-running count.
                    if (abort) begin
                        aborted    <= 1'b1;
                        busy       <= 1'b0;
                        last_count <= cnt_count;
                        state      <= StIdle;
                    end else if (target_q == '0) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        last_count <= cnt_count;
                        state      <= StDone;
                    end else begin
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (abort) begin
                        aborted    <= 1'b1;
                        busy       <= 1'b0;
                        last_count <= cnt_count;
                        state      <= StIdle;
                    end else if (cnt_rollover) begin
                        if (wrap_cnt != WrapMax) begin
                            wrap_cnt <= wrap_next[WRAP_W-1:0];
                        end
                        if (wrap_next == {1'b0, target_q}) begin
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            last_count <= cnt_count;
                            state      <= StDone;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
